// File: rtl/apb_pkg.sv
// Shared types and helpers for the multi-slave APB master.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // One spare bit so that out-of-range slave indices can be presented and rejected.
  function automatic int sel_width(input int num_slaves);
    return $clog2(num_slaves) + 1;
  endfunction

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles; expired flags the last cycle allowed before abort.
module apb_timeout_counter #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign expired = (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_master_mc.sv
// Processor-bus to APB bridge for NUM_SLAVES slaves with one-hot PSEL,
// wait-state timeout and PSLVERR propagation.
//
//   state  | meaning
//   IDLE   | no transfer; start accepted here (bad sel answered with error pulse)
//   SETUP  | psel driven, penable low, one cycle
//   ACCESS | penable high, waiting for pready of the selected slave or timeout
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           write,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [DATA_W-1:0]              wdata,
  input  logic [sel_width(NUM_SLAVES)-1:0] sel,
  output logic [DATA_W-1:0]              rdata,
  output logic                           stable,
  output logic                           error,
  output logic                           busy,
  output logic [NUM_SLAVES-1:0]          psel,
  output logic                           penable,
  output logic                           pwrite,
  output logic [ADDR_W-1:0]              paddr,
  output logic [DATA_W-1:0]              pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0]   prdata,
  input  logic [NUM_SLAVES-1:0]          pready,
  input  logic [NUM_SLAVES-1:0]          pslverr
);

  localparam int SEL_W = sel_width(NUM_SLAVES);
  localparam logic [SEL_W-1:0]      SEL_LIMIT = SEL_W'(NUM_SLAVES);
  localparam logic [NUM_SLAVES-1:0] ONE_HOT_0 = NUM_SLAVES'(1);

  apb_state_t              r_state;
  logic [NUM_SLAVES-1:0]   r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_W-1:0]       r_paddr;
  logic [DATA_W-1:0]       r_pwdata;
  logic [DATA_W-1:0]       r_rdata;
  logic                    r_stable;
  logic                    r_error;

  logic                    w_sel_ok;
  logic                    w_accept;
  logic                    w_pready;
  logic                    w_pslverr;
  logic                    w_expired;
  logic [DATA_W-1:0]       w_prdata;

  assign w_sel_ok  = (sel < SEL_LIMIT);
  assign w_accept  = (r_state == IDLE) && start && w_sel_ok;
  // r_psel is one-hot during a transfer, so masking isolates the selected slave.
  assign w_pready  = |(pready & r_psel);
  assign w_pslverr = |(pslverr & r_psel);

  always_comb begin
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_psel[i]) w_prdata = w_prdata | prdata[i*DATA_W +: DATA_W];
    end
  end

  apb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (w_accept),
    .en      ((r_state == ACCESS) && !w_pready),
    .expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_psel    <= '0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_stable  <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_stable <= 1'b0;
      r_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_sel_ok) begin
              r_state  <= SETUP;
              r_psel   <= ONE_HOT_0 << sel;
              r_pwrite <= write;
              r_paddr  <= addr;
              r_pwdata <= wdata;
            end else begin
              r_stable <= 1'b1;
              r_error  <= 1'b1;
            end
          end
        end
        SETUP: begin
          r_state   <= ACCESS;
          r_penable <= 1'b1;
        end
        ACCESS: begin
          if (w_pready) begin
            r_state   <= IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_stable  <= 1'b1;
            r_error   <= w_pslverr;
            if (!r_pwrite) r_rdata <= w_prdata;
          end else if (w_expired) begin
            r_state   <= IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
            r_stable  <= 1'b1;
            r_error   <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign psel    = r_psel;
  assign penable = r_penable;
  assign pwrite  = r_pwrite;
  assign paddr   = r_paddr;
  assign pwdata  = r_pwdata;
  assign rdata   = r_rdata;
  assign stable  = r_stable;
  assign error   = r_error;
  assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc (4 slaves, 8-bit, TIMEOUT=8).
module tb_apb_master_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        write;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [2:0]  sel;
  logic [7:0]  rdata;
  logic        stable;
  logic        error;
  logic        busy;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [31:0] prdata;
  logic [3:0]  pready;
  logic [3:0]  pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  apb_master_mc #(
    .ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .addr(addr),
    .wdata(wdata), .sel(sel), .rdata(rdata), .stable(stable), .error(error),
    .busy(busy), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; write = 1'b0; addr = '0; wdata = '0; sel = '0;
    prdata = '0; pready = '0; pslverr = '0;
    tick(); tick();
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata, rdata, stable, error, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rdata=%h stb=%b err=%b busy=%b required all zero",
               psel, penable, pwrite, paddr, pwdata, rdata, stable, error, busy);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_write_zero_wait();
    pready = 4'b0010;
    start = 1'b1; write = 1'b1; sel = 3'd1; addr = 8'h41; wdata = 8'h05;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite, paddr, pwdata, busy} !== {4'b0010, 1'b0, 1'b1, 8'h41, 8'h05, 1'b1}) begin
      n_bad++;
      $display("FAIL write_setup: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h busy=%b required 0010 0 1 41 05 1",
               psel, penable, pwrite, paddr, pwdata, busy);
    end
    tick();
    n_cmp++;
    if ({psel, penable, pwdata, stable} !== {4'b0010, 1'b1, 8'h05, 1'b0}) begin
      n_bad++;
      $display("FAIL write_access: got psel=%b pen=%b pwdata=%h stb=%b required 0010 1 05 0",
               psel, penable, pwdata, stable);
    end
    tick();
    n_cmp++;
    if ({stable, error, psel, penable, busy, pwdata} !== {1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 8'h05}) begin
      n_bad++;
      $display("FAIL write_done: got stb=%b err=%b psel=%b pen=%b busy=%b pwdata=%h required 1 0 0000 0 0 05",
               stable, error, psel, penable, busy, pwdata);
    end
    tick();
    n_cmp++;
    if ({stable, error} !== 2'b00) begin
      n_bad++;
      $display("FAIL write_pulse_width: got stb=%b err=%b required 0 0", stable, error);
    end
  endtask

  task automatic test_read_wait3();
    prdata = {8'h77, 8'hA5, 8'h22, 8'h11};
    pready = 4'b1001;
    pslverr = 4'b0011;
    start = 1'b1; write = 1'b0; sel = 3'd2; addr = 8'h41;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({psel, penable, pwrite} !== {4'b0100, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL read_setup: got psel=%b pen=%b pwr=%b required 0100 0 0", psel, penable, pwrite);
    end
    for (int cyc = 2; cyc <= 5; cyc++) begin
      tick();
      n_cmp++;
      if ({penable, stable, psel} !== {1'b1, 1'b0, 4'b0100}) begin
        n_bad++;
        $display("FAIL read_wait_c%0d: got pen=%b stb=%b psel=%b required 1 0 0100", cyc, penable, stable, psel);
      end
      if (cyc == 5) pready = 4'b1101;
    end
    tick();
    n_cmp++;
    if ({stable, error, rdata, psel} !== {1'b1, 1'b0, 8'hA5, 4'b0000}) begin
      n_bad++;
      $display("FAIL read_done: got stb=%b err=%b rdata=%h psel=%b required 1 0 a5 0000", stable, error, rdata, psel);
    end
    pready = '0; pslverr = '0;
  endtask

  task automatic test_timeout();
    int acc = 0;
    int guard = 0;
    pready = 4'b0000;
    start = 1'b1; write = 1'b0; sel = 3'd3; addr = 8'h10;
    tick();
    start = 1'b0;
    tick();
    while (!stable && guard < 40) begin
      if (penable) acc++;
      tick();
      guard++;
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL timeout_bound: got no stable within 40 cycles required stable pulse");
    end
    n_cmp++;
    if (acc !== 8) begin
      n_bad++;
      $display("FAIL timeout_access_len: got %0d ACCESS cycles required 8", acc);
    end
    n_cmp++;
    if ({stable, error, psel, penable, rdata} !== {1'b1, 1'b1, 4'b0000, 1'b0, 8'hA5}) begin
      n_bad++;
      $display("FAIL timeout_done: got stb=%b err=%b psel=%b pen=%b rdata=%h required 1 1 0000 0 a5",
               stable, error, psel, penable, rdata);
    end
    tick();
    pready = 4'b1000;
    start = 1'b1; write = 1'b1; sel = 3'd3; addr = 8'h12; wdata = 8'h9C;
    tick();
    start = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({stable, error, pwdata, paddr} !== {1'b1, 1'b0, 8'h9C, 8'h12}) begin
      n_bad++;
      $display("FAIL after_timeout_xfer: got stb=%b err=%b pwdata=%h paddr=%h required 1 0 9c 12",
               stable, error, pwdata, paddr);
    end
    pready = '0;
    tick();
  endtask

  task automatic test_slave_error_bad_sel();
    prdata = {8'h77, 8'hA5, 8'h22, 8'h3C};
    pready = 4'b0001; pslverr = 4'b0001;
    start = 1'b1; write = 1'b0; sel = 3'd0; addr = 8'h05;
    tick();
    start = 1'b0;
    tick(); tick();
    n_cmp++;
    if ({stable, error, rdata} !== {1'b1, 1'b1, 8'h3C}) begin
      n_bad++;
      $display("FAIL slverr_done: got stb=%b err=%b rdata=%h required 1 1 3c", stable, error, rdata);
    end
    tick();
    n_cmp++;
    if ({stable, error} !== 2'b00) begin
      n_bad++;
      $display("FAIL slverr_clear: got stb=%b err=%b required 0 0", stable, error);
    end
    pready = 4'b1111; pslverr = '0;
    start = 1'b1; sel = 3'd5; addr = 8'hEE; write = 1'b1; wdata = 8'h33;
    tick();
    start = 1'b0;
    n_cmp++;
    if ({stable, error, psel, busy, penable, paddr} !== {1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 8'h05}) begin
      n_bad++;
      $display("FAIL bad_sel: got stb=%b err=%b psel=%b busy=%b pen=%b paddr=%h required 1 1 0000 0 0 05",
               stable, error, psel, busy, penable, paddr);
    end
    tick();
    n_cmp++;
    if ({stable, error, psel} !== {1'b0, 1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL bad_sel_after: got stb=%b err=%b psel=%b required 0 0 0000", stable, error, psel);
    end
    pready = '0;
  endtask

  task automatic test_back_to_back();
    pready = 4'b0010;
    start = 1'b1; write = 1'b1; sel = 3'd1; addr = 8'h20; wdata = 8'h61;
    tick();
    tick();
    n_cmp++;
    if ({psel, penable, busy} !== {4'b0010, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL b2b_access1: got psel=%b pen=%b busy=%b required 0010 1 1", psel, penable, busy);
    end
    wdata = 8'h62; addr = 8'h21;
    tick();
    n_cmp++;
    if ({stable, error, busy} !== {1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL b2b_done1: got stb=%b err=%b busy=%b required 1 0 0", stable, error, busy);
    end
    tick();
    start = 1'b0;
    n_cmp++;
    if ({psel, penable, busy, paddr, pwdata} !== {4'b0010, 1'b0, 1'b1, 8'h21, 8'h62}) begin
      n_bad++;
      $display("FAIL b2b_setup2: got psel=%b pen=%b busy=%b paddr=%h pwdata=%h required 0010 0 1 21 62",
               psel, penable, busy, paddr, pwdata);
    end
    tick(); tick();
    n_cmp++;
    if ({stable, error} !== 2'b10) begin
      n_bad++;
      $display("FAIL b2b_done2: got stb=%b err=%b required 1 0", stable, error);
    end
    tick();
    n_cmp++;
    if ({busy, stable, psel} !== {1'b0, 1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL b2b_idle: got busy=%b stb=%b psel=%b required 0 0 0000", busy, stable, psel);
    end
  endtask

  task automatic test_reset_abort();
    pready = 4'b0000;
    start = 1'b1; write = 1'b1; sel = 3'd2; addr = 8'h55; wdata = 8'hAA;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pready = 4'b0100;
    n_cmp++;
    if ({psel, penable, busy, stable, paddr, pwdata, rdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_abort: got psel=%b pen=%b busy=%b stb=%b paddr=%h pwdata=%h rdata=%h required all zero",
               psel, penable, busy, stable, paddr, pwdata, rdata);
    end
    tick();
    n_cmp++;
    if ({stable, busy, psel} !== {1'b0, 1'b0, 4'b0000}) begin
      n_bad++;
      $display("FAIL reset_abort_after: got stb=%b busy=%b psel=%b required 0 0 0000", stable, busy, psel);
    end
    pready = '0;
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_timeout();
    test_slave_error_bad_sel();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
